// File: rtl/user_au_stream_router_if.sv
// Stream interface for user_au_stream_router: source-side sample port and
// sink-side tagged FIFO port.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid must not depend on ready, and data/tag are held
// stable while valid is high and ready is low.
interface user_au_stream_router_if #(
    parameter int DataWidth = 32,
    parameter int TagW      = 1
);
    logic [DataWidth-1:0] in_data_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [DataWidth-1:0] out_data_o;
    logic [TagW-1:0]      out_chan_o;
    logic                 out_valid_o;
    logic                 out_ready_i;

    // Router side
    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_chan_o, out_valid_o
    );

    // Source/sink side
    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_chan_o, out_valid_o
    );
endinterface

// File: rtl/user_au_stream_router.sv
// user_au_stream_router: routes a tagged audio sample stream through
// NumStages external stages in index order, skipping stages set in a runtime
// bypass mask. Mask changes wait until no sample is in flight. Results land in
// a registered output FIFO with their interleaved channel tag.
// Optional feature macro: AU_ROUTER_PEAK_EN adds per-channel peak |sample|
// registers (peak_o) with a clear input (peak_clr_i).
module user_au_stream_router #(
    parameter int DataWidth   = 32,
    parameter int NumStages   = 4,
    parameter int NumChannels = 2,
    parameter int FifoDepth   = 4,
    parameter int MaxInFlight = 8,
    localparam int TagW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int IfW  = $clog2(MaxInFlight + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    user_au_stream_router_if.slave         au,
    output logic [NumStages*DataWidth-1:0] stg_data_o,
    output logic [NumStages-1:0]           stg_valid_o,
    input  logic [NumStages-1:0]           stg_ready_i,
    input  logic [NumStages*DataWidth-1:0] stg_data_i,
    input  logic [NumStages-1:0]           stg_valid_i,
    output logic [NumStages-1:0]           stg_ready_o,
    input  logic [NumStages-1:0]           cfg_bypass_i,
    input  logic                           cfg_update_i,
    output logic                           busy_o,
    output logic [IfW-1:0]                 inflight_o
`ifdef AU_ROUTER_PEAK_EN
    ,
    input  logic                             peak_clr_i,
    output logic [NumChannels*DataWidth-1:0] peak_o
`endif
);
    localparam int TPtrW = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
    localparam int OPtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OCntW = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_APPLY} state_t;

    state_t               state_q;
    logic [NumStages-1:0] mask_q;
    logic [NumStages-1:0] pend_q;
    logic [TagW-1:0]      chan_q;
    logic [IfW-1:0]       inflight_q;
    logic [TagW-1:0]      tag_mem_q [MaxInFlight];
    logic [TPtrW-1:0]     tag_wr_q;
    logic [TPtrW-1:0]     tag_rd_q;
    logic [DataWidth-1:0] odata_q [FifoDepth];
    logic [TagW-1:0]      otag_q [FifoDepth];
    logic [OPtrW-1:0]     owr_q;
    logic [OPtrW-1:0]     ord_q;
    logic [OCntW-1:0]     ocnt_q;

    logic                 accept_ok;
    logic                 head_r;
    logic [DataWidth-1:0] end_d;
    logic                 end_v;
    logic                 fifo_wr_ok;
    logic                 accept;
    logic                 retire;
    logic                 pop;
    logic [TagW-1:0]      ret_tag;

    function automatic logic [TPtrW-1:0] tinc(input logic [TPtrW-1:0] p);
        return (p == TPtrW'(MaxInFlight - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [OPtrW-1:0] oinc(input logic [OPtrW-1:0] p);
        return (p == OPtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept_ok      = (state_q == ST_RUN) && (inflight_q < IfW'(MaxInFlight));
    assign au.in_ready_o  = accept_ok && head_r;
    assign accept         = au.in_valid_i && au.in_ready_o;
    assign pop            = au.out_valid_o && au.out_ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
    assign fifo_wr_ok     = (ocnt_q != OCntW'(FifoDepth)) || pop;
    assign retire         = end_v && fifo_wr_ok;
    // With nothing in flight the retiring sample is the one being accepted now.
    assign ret_tag        = (inflight_q == '0) ? chan_q : tag_mem_q[tag_rd_q];
    assign au.out_valid_o = (ocnt_q != '0);
    assign au.out_data_o  = odata_q[ord_q];
    assign au.out_chan_o  = otag_q[ord_q];
    assign busy_o         = (state_q != ST_RUN);
    assign inflight_o     = inflight_q;

    // Forward path: source valid/data ripple through the unbypassed stages to the FIFO.
    always_comb begin
        logic [DataWidth-1:0] cur_d;
        logic                 cur_v;
        cur_d       = au.in_data_i;
        cur_v       = au.in_valid_i && accept_ok;
        stg_data_o  = '0;
        stg_valid_o = '0;
        for (int k = 0; k < NumStages; k++) begin
            if (!mask_q[k]) begin
                stg_data_o[k*DataWidth +: DataWidth] = cur_d;
                stg_valid_o[k]                       = cur_v;
                cur_d = stg_data_i[k*DataWidth +: DataWidth];
                cur_v = stg_valid_i[k];
            end
        end
        end_d = cur_d;
        end_v = cur_v;
    end

    // Backward path: FIFO space ripples back through the unbypassed stages to the source.
    always_comb begin
        logic cur_r;
        cur_r       = fifo_wr_ok;
        stg_ready_o = '0;
        for (int k = NumStages - 1; k >= 0; k--) begin
            if (!mask_q[k]) begin
                stg_ready_o[k] = cur_r;
                cur_r          = stg_ready_i[k];
            end
        end
        head_r = cur_r;
    end

    // Reconfiguration FSM: latch request, wait for in-flight to empty, then swap mask.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            mask_q  <= '0;
            pend_q  <= '0;
        end else begin
            if (cfg_update_i) pend_q <= cfg_bypass_i;
            case (state_q)
                ST_RUN:   if (cfg_update_i) state_q <= ST_DRAIN;
                ST_DRAIN: if (inflight_q == '0) state_q <= ST_APPLY;
                ST_APPLY: begin
                    // A request landing in this very cycle is the newest one, so it wins.
                    mask_q  <= cfg_update_i ? cfg_bypass_i : pend_q;
                    state_q <= ST_RUN;
                end
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    // Channel counter, in-flight count and tag FIFO (one tag per accepted sample).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chan_q     <= '0;
            inflight_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            for (int i = 0; i < MaxInFlight; i++) tag_mem_q[i] <= '0;
        end else begin
            if (accept) begin
                tag_mem_q[tag_wr_q] <= chan_q;
                tag_wr_q            <= tinc(tag_wr_q);
                chan_q <= (chan_q == TagW'(NumChannels - 1)) ? '0 : chan_q + 1'b1;
            end
            if (retire) tag_rd_q <= tinc(tag_rd_q);
            case ({accept, retire})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Output FIFO holding {tag, data}; head is read straight from registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owr_q  <= '0;
            ord_q  <= '0;
            ocnt_q <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                odata_q[i] <= '0;
                otag_q[i]  <= '0;
            end
        end else begin
            if (retire) begin
                odata_q[owr_q] <= end_d;
                otag_q[owr_q]  <= ret_tag;
                owr_q          <= oinc(owr_q);
            end
            if (pop) ord_q <= oinc(ord_q);
            case ({retire, pop})
                2'b10:   ocnt_q <= ocnt_q + 1'b1;
                2'b01:   ocnt_q <= ocnt_q - 1'b1;
                default: ocnt_q <= ocnt_q;
            endcase
        end
    end

`ifdef AU_ROUTER_PEAK_EN
    logic [DataWidth-1:0] peak_q [NumChannels];
    logic [DataWidth-1:0] wr_abs;

    // |sample| of the FIFO write; the most negative value saturates to max positive.
    always_comb begin
        if (end_d == {1'b1, {(DataWidth-1){1'b0}}}) wr_abs = {1'b0, {(DataWidth-1){1'b1}}};
        else if (end_d[DataWidth-1])                wr_abs = ~end_d + 1'b1;
        else                                        wr_abs = end_d;
    end

    // Per-channel running peak; a write in the clear cycle seeds that channel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChannels; c++) peak_q[c] <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (peak_clr_i) begin
                    peak_q[c] <= (retire && ret_tag == TagW'(c)) ? wr_abs : '0;
                end else if (retire && ret_tag == TagW'(c) && wr_abs > peak_q[c]) begin
                    peak_q[c] <= wr_abs;
                end
            end
        end
    end

    // Flatten the peak registers onto the output bus, channel 0 in the low slice.
    always_comb begin
        peak_o = '0;
        for (int c = 0; c < NumChannels; c++) peak_o[c*DataWidth +: DataWidth] = peak_q[c];
    end
`endif
endmodule

// File: tb/tb_user_au_stream_router.sv
// Bench for user_au_stream_router: behavioural +1 stage models with one-entry
// buffers, a scoreboard queue of expected {tag,data}, and scenario tasks.
module tb_user_au_stream_router;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int NC  = 2;
  localparam int FD  = 4;
  localparam int MIF = 8;
  localparam int TW  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS*DW-1:0] stg_data_o, stg_data_i;
  logic [NS-1:0]    stg_valid_o, stg_ready_i, stg_valid_i, stg_ready_o;
  logic [NS-1:0]    cfg_bypass;
  logic             cfg_update;
  logic             busy;
  logic [3:0]       inflight;
`ifdef AU_ROUTER_PEAK_EN
  logic             peak_clr;
  logic [NC*DW-1:0] peak;
`endif

  user_au_stream_router_if #(.DataWidth(DW), .TagW(TW)) au ();

  user_au_stream_router #(
    .DataWidth(DW), .NumStages(NS), .NumChannels(NC), .FifoDepth(FD), .MaxInFlight(MIF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .au(au.slave),
    .stg_data_o(stg_data_o), .stg_valid_o(stg_valid_o), .stg_ready_i(stg_ready_i),
    .stg_data_i(stg_data_i), .stg_valid_i(stg_valid_i), .stg_ready_o(stg_ready_o),
    .cfg_bypass_i(cfg_bypass), .cfg_update_i(cfg_update),
    .busy_o(busy), .inflight_o(inflight)
`ifdef AU_ROUTER_PEAK_EN
    , .peak_clr_i(peak_clr), .peak_o(peak)
`endif
  );

  // stage models: one entry, +1, result valid one cycle after capture, hold[k] freezes output
  logic [NS-1:0] st_busy, st_cnt, hold;
  logic [DW-1:0] st_data [NS];

  always_comb begin
    stg_data_i  = '0;
    stg_valid_i = '0;
    stg_ready_i = '0;
    for (int k = 0; k < NS; k++) begin
      stg_valid_i[k] = st_busy[k] && !st_cnt[k] && !hold[k];
      stg_ready_i[k] = !st_busy[k];
      stg_data_i[k*DW +: DW] = st_data[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (rst) begin
        st_busy[k] <= 1'b0;
        st_cnt[k]  <= 1'b0;
        st_data[k] <= '0;
      end else if (!st_busy[k] && stg_valid_o[k]) begin
        st_busy[k] <= 1'b1;
        st_cnt[k]  <= 1'b1;
        st_data[k] <= stg_data_o[k*DW +: DW] + 32'd1;
      end else if (st_busy[k]) begin
        if (st_cnt[k]) st_cnt[k] <= 1'b0;
        else if (!hold[k] && stg_ready_o[k]) st_busy[k] <= 1'b0;
      end
    end
  end

  // scoreboard
  logic [TW+DW-1:0] exp_q[$];
  logic [NS-1:0]    tb_mask;
  logic [TW-1:0]    tb_chan;
  int               errors = 0;
  int               checks = 0;
  bit               watch02 = 0;
  bit               saw02 = 0;
  bit               rnd_en = 0;

  always @(negedge clk) begin
    logic [DW-1:0]    e;
    logic [TW+DW-1:0] got, want;
    if (!rst) begin
      if (watch02 && (stg_valid_o[0] || stg_valid_o[2])) saw02 = 1;
      if (au.in_valid_i && au.in_ready_o) begin
        e = au.in_data_i + DW'(NS - $countones(tb_mask));
        exp_q.push_back({tb_chan, e});
        tb_chan = (tb_chan == TW'(NC - 1)) ? '0 : tb_chan + 1'b1;
      end
      if (au.out_valid_o && au.out_ready_i) begin
        checks++;
        got = {au.out_chan_o, au.out_data_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got tag/data %h, expected nothing", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL sb_out: got tag/data %h, expected %h", got, want);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) au.out_ready_i = 1'($urandom_range(0, 1));
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic push(input logic [DW-1:0] d);
    bit ok = 0;
    au.in_data_i  = d;
    au.in_valid_i = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = au.in_ready_o;
      @(posedge clk);
      #1;
    end
    au.in_valid_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: sample %h not accepted, required accept", d);
    end
  endtask

  task automatic cfg(input logic [NS-1:0] m);
    bit done = 0;
    cfg_bypass = m;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cfg_done: busy_o stuck at 1, required 0");
    end
    @(posedge clk);
    #1;
    tb_mask = m;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    au.in_valid_i = 1'b0;
    cfg_update = 1'b0;
    hold = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tb_chan = '0;
    tb_mask = '0;
  endtask

  // scenario tasks
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (au.out_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", au.out_valid_o);
    end
    checks++;
    if (inflight !== 4'd0) begin
      errors++; $display("FAIL reset_inflight: got %0d, required 0", inflight);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, required 0", busy);
    end
    checks++;
    if (stg_valid_o !== 4'b0) begin
      errors++; $display("FAIL reset_stg_valid: got %b, required 0000", stg_valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass_all();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    au.out_ready_i = 1'b1;
    // reconfigure with nothing in flight: busy for exactly two cycles
    cfg_bypass = 4'b1111;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== (i < 2)) begin
        errors++; $display("FAIL reconfig_busy_%0d: got %b, required %b", i, busy, (i < 2));
      end
    end
    @(posedge clk);
    #1;
    tb_mask = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      push(vals[i]);
      @(negedge clk);
      checks++;
      if (au.out_valid_o !== 1'b1 || au.out_data_o !== vals[i]) begin
        errors++;
        $display("FAIL bypass_latency_%0d: got valid %b data %h, required 1 %h",
                 i, au.out_valid_o, au.out_data_o, vals[i]);
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_partial_mask();
    do_reset();
    au.out_ready_i = 1'b1;
    cfg(4'b0101);
    saw02 = 0;
    watch02 = 1;
    push(32'h100);
    wait_drain();
    watch02 = 0;
    checks++;
    if (saw02) begin
      errors++; $display("FAIL bypassed_valid: stage 0/2 saw valid 1, required 0");
    end
  endtask

  task automatic test_fifo_full();
    cfg(4'b1111);
    au.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    au.in_data_i  = 32'hA4;
    au.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (au.in_ready_o !== 1'b0) begin
        errors++; $display("FAIL full_in_ready_%0d: got %b, required 0", i, au.in_ready_o);
      end
      @(posedge clk);
      #1;
    end
    au.out_ready_i = 1'b1;
    push(32'hA4);
    push(32'hA5);
    wait_drain();
  endtask

  task automatic test_drain();
    bit hit = 0;
    do_reset();
    au.out_ready_i = 1'b1;
    hold[3] = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i));
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (inflight !== 4'd3) begin
      errors++; $display("FAIL drain_inflight3: got %0d, required 3", inflight);
    end
    cfg_bypass = 4'b1111;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
    hold[3] = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || au.in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL drain_block: got busy %b in_ready %b, required 1 0", busy, au.in_ready_o);
      end
      hit = (inflight == 4'd0);
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL drain_empty: in-flight never reached 0, required 0");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL drain_apply_busy: got %b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drain_run_busy: got %b, required 0", busy);
    end
    @(posedge clk);
    #1;
    tb_mask = 4'b1111;
    push(32'h55);
    @(negedge clk);
    checks++;
    if (au.out_valid_o !== 1'b1 || au.out_data_o !== 32'h55) begin
      errors++;
      $display("FAIL new_mask_active: got valid %b data %h, required 1 00000055",
               au.out_valid_o, au.out_data_o);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    au.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
    cfg(4'b0000);
    hold[3] = 1'b1;
    push(32'h310);
    push(32'h311);
    @(negedge clk);
    checks++;
    if (inflight !== 4'd2) begin
      errors++; $display("FAIL mid_inflight2: got %0d, required 2", inflight);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold = '0;
    exp_q.delete();
    tb_chan = '0;
    tb_mask = '0;
    @(negedge clk);
    checks++;
    if (au.out_valid_o !== 1'b0 || inflight !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got out_valid %b inflight %0d, required 0 0",
               au.out_valid_o, inflight);
    end
    @(posedge clk);
    #1;
    au.out_ready_i = 1'b1;
    push(32'h77);
    for (int n = 0; n < 100 && !au.out_valid_o; n++) @(negedge clk);
    checks++;
    if (au.out_valid_o !== 1'b1 || au.out_chan_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_first_tag: got valid %b tag %0d, required 1 0",
               au.out_valid_o, au.out_chan_o);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      cfg(4'($urandom_range(0, 15)));
      rnd_en = 1;
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        push($urandom());
      end
      rnd_en = 0;
      @(posedge clk);
      #1;
      au.out_ready_i = 1'b1;
      wait_drain();
    end
  endtask

`ifdef AU_ROUTER_PEAK_EN
  task automatic peak_check(input string name, input logic [DW-1:0] want);
    @(negedge clk);
    checks++;
    if (peak[DW-1:0] !== want) begin
      errors++; $display("FAIL %s: got %h, required %h", name, peak[DW-1:0], want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_peak();
    peak_clr = 1'b0;
    do_reset();
    au.out_ready_i = 1'b1;
    cfg(4'b1111);
    push(-32'sd5);
    peak_check("peak_neg5", 32'd5);
    push(32'd0);
    push(32'd3);
    peak_check("peak_keep5", 32'd5);
    push(32'd0);
    push(32'h8000_0000);
    peak_check("peak_sat", 32'h7FFF_FFFF);
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    peak_check("peak_clr", 32'd0);
    wait_drain();
  endtask
`endif

  initial begin
    rst            = 1'b1;
    au.in_data_i   = '0;
    au.in_valid_i  = 1'b0;
    au.out_ready_i = 1'b0;
    cfg_bypass     = '0;
    cfg_update     = 1'b0;
    hold           = '0;
    tb_mask        = '0;
    tb_chan        = '0;
`ifdef AU_ROUTER_PEAK_EN
    peak_clr       = 1'b0;
`endif
    test_reset();
    test_bypass_all();
    test_partial_mask();
    test_fifo_full();
    test_drain();
    test_reset_mid();
    test_back_to_back();
`ifdef AU_ROUTER_PEAK_EN
    test_peak();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
